// File: rtl/palu_acc_seq.sv
// Accumulator/sequencer stage for the 8-bit partial ALU: takes op/operand commands, folds ALU results
// into an accumulator and hands the final value downstream. Optional macro PALU_SAT_ADD_EN saturates ADD.
module palu_acc_seq #(
   parameter logic [7:0] ACC_INIT = 8'h00,
   parameter int         CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [7:0]       cmd_operand,
   input  logic             cmd_last,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [1:0]       alu_sel,
   input  logic [7:0]       alu_f,
   input  logic             alu_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic             res_ovf,
   output logic [CNT_W-1:0] res_cnt,
   output logic [7:0]       acc
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOT  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;

   logic [2:0]       op_r;
   logic [7:0]       operand_r;
   logic             last_r;
   logic [7:0]       acc_r;
   logic             ovf_r;
   logic [CNT_W-1:0] cnt_r;

   logic [7:0]       acc_nxt_s;
   logic             ovf_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;

   logic             cmd_ready_r;
   logic             res_valid_r;
   logic [7:0]       res_data_r;
   logic             res_ovf_r;
   logic [CNT_W-1:0] res_cnt_r;

   logic             cmd_ready_nxt_s;
   logic             res_valid_nxt_s;
   logic [7:0]       res_data_nxt_s;
   logic             res_ovf_nxt_s;
   logic [CNT_W-1:0] res_cnt_nxt_s;

   logic             cmd_fire_s;
   logic             res_fire_s;

   assign cmd_fire_s = cmd_valid & cmd_ready_r;
   assign res_fire_s = res_valid_r & res_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic: every command spends exactly one cycle in EXEC
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (last_r) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (res_fire_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Accumulator, sticky overflow and op counter update
   always_comb begin
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
      cnt_nxt_s = cnt_r;
      case (state_r)
         ST_EXEC: begin
            case (op_r)
               OP_ADD: begin
`ifdef PALU_SAT_ADD_EN
                  if (alu_ovf) begin
                     acc_nxt_s = 8'hFF;
                  end else begin
                     acc_nxt_s = alu_f;
                  end
`else
                  acc_nxt_s = alu_f;
`endif
                  ovf_nxt_s = ovf_r | alu_ovf;
               end
               OP_NOT, OP_AND, OP_OR: begin
                  acc_nxt_s = alu_f;
               end
               OP_LOAD: begin
                  acc_nxt_s = operand_r;
               end
               default: begin
                  acc_nxt_s = acc_r;
               end
            endcase
            if (cnt_r == CNT_MAX) begin
               cnt_nxt_s = cnt_r;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (res_fire_s) begin
               acc_nxt_s = ACC_INIT;
               ovf_nxt_s = 1'b0;
               cnt_nxt_s = CNT_ZERO;
            end else begin
               acc_nxt_s = acc_r;
               ovf_nxt_s = ovf_r;
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            acc_nxt_s = acc_r;
         end
      endcase
   end

   // Datapath registers; the command is captured only on an accepted handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= 3'd0;
         operand_r <= 8'h00;
         last_r    <= 1'b0;
         acc_r     <= ACC_INIT;
         ovf_r     <= 1'b0;
         cnt_r     <= CNT_ZERO;
      end else begin
         if (cmd_fire_s) begin
            op_r      <= cmd_op;
            operand_r <= cmd_operand;
            last_r    <= cmd_last;
         end else begin
            op_r      <= op_r;
            operand_r <= operand_r;
            last_r    <= last_r;
         end
         acc_r <= acc_nxt_s;
         ovf_r <= ovf_nxt_s;
         cnt_r <= cnt_nxt_s;
      end
   end

   // Output decode from the upcoming state so handshake/result outputs can be registered
   always_comb begin
      cmd_ready_nxt_s = 1'b0;
      res_valid_nxt_s = 1'b0;
      res_data_nxt_s  = 8'h00;
      res_ovf_nxt_s   = 1'b0;
      res_cnt_nxt_s   = CNT_ZERO;
      case (state_nxt_s)
         ST_IDLE: begin
            cmd_ready_nxt_s = 1'b1;
         end
         ST_HOLD: begin
            res_valid_nxt_s = 1'b1;
            res_data_nxt_s  = acc_nxt_s;
            res_ovf_nxt_s   = ovf_nxt_s;
            res_cnt_nxt_s   = cnt_nxt_s;
         end
         default: begin
            cmd_ready_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_r <= 1'b1;
         res_valid_r <= 1'b0;
         res_data_r  <= 8'h00;
         res_ovf_r   <= 1'b0;
         res_cnt_r   <= CNT_ZERO;
      end else begin
         cmd_ready_r <= cmd_ready_nxt_s;
         res_valid_r <= res_valid_nxt_s;
         res_data_r  <= res_data_nxt_s;
         res_ovf_r   <= res_ovf_nxt_s;
         res_cnt_r   <= res_cnt_nxt_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign res_valid = res_valid_r;
   assign res_data  = res_data_r;
   assign res_ovf   = res_ovf_r;
   assign res_cnt   = res_cnt_r;
   assign acc       = acc_r;
   assign alu_a     = acc_r;
   assign alu_b     = operand_r;
   assign alu_sel   = op_r[1:0];

endmodule

// File: tb/tb_palu_acc_seq.sv
// Self-checking bench for palu_acc_seq: a small ALU stub closes the loop, and a command-level
// reference model predicts each sequence result. Honours PALU_SAT_ADD_EN when it is defined.
module tb_palu_acc_seq;

   localparam logic [7:0] INIT = 8'h00;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_last;
   logic [2:0] cmd_op;
   logic [7:0] cmd_operand;
   logic [7:0] alu_a, alu_b, alu_f;
   logic [1:0] alu_sel;
   logic       alu_ovf;
   logic       res_valid, res_ready, res_ovf;
   logic [7:0] res_data, acc;
   logic [3:0] res_cnt;

   int errors = 0;
   int checks = 0;

   logic [2:0] q_op[$];
   logic [7:0] q_opd[$];

   always #5 clk = ~clk;

   palu_acc_seq #(.ACC_INIT(INIT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_operand(cmd_operand), .cmd_last(cmd_last),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f), .alu_ovf(alu_ovf),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .res_cnt(res_cnt), .acc(acc)
   );

   // ALU stub: ADD with carry-out as overflow, NOT of b, AND, OR
   always_comb begin
      logic [8:0] sum;
      sum     = {1'b0, alu_a} + {1'b0, alu_b};
      alu_f   = 8'h00;
      alu_ovf = 1'b0;
      case (alu_sel)
         2'd0: begin alu_f = sum[7:0]; alu_ovf = sum[8]; end
         2'd1: alu_f = ~alu_b;
         2'd2: alu_f = alu_a & alu_b;
         default: alu_f = alu_a | alu_b;
      endcase
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Command-level reference: fold the queued commands into (data, sticky ovf, saturating count)
   function automatic void ref_model(output logic [7:0] d, output logic o, output logic [3:0] c);
      int a, n, s;
      a = INIT; o = 1'b0; n = 0;
      for (int i = 0; i < q_op.size(); i++) begin
         case (q_op[i])
            3'd0: begin
               s = a + q_opd[i];
               if (s > 255) o = 1'b1;
`ifdef PALU_SAT_ADD_EN
               a = (s > 255) ? 255 : s;
`else
               a = s % 256;
`endif
            end
            3'd1: a = 255 - q_opd[i];
            3'd2: a = a & q_opd[i];
            3'd3: a = a | q_opd[i];
            3'd4: a = q_opd[i];
            default: a = a;
         endcase
         if (n < 15) n = n + 1;
      end
      d = a[7:0];
      c = n[3:0];
   endfunction

   task automatic send_cmd(input logic [2:0] op, input logic [7:0] opd, input logic last,
                           output int waits);
      cmd_valid = 1'b1; cmd_op = op; cmd_operand = opd; cmd_last = last;
      waits = 0;
      while (cmd_ready !== 1'b1 && waits < 20) begin
         tick();
         waits++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waits);
      end
      tick();
      cmd_valid = 1'b0;
      cmd_op = 3'($urandom); cmd_operand = 8'($urandom); cmd_last = 1'($urandom);
   endtask

   // Drive the queued sequence, then check result timing, contents, hold and handoff
   task automatic run_seq(input string nm, input logic [7:0] ed, input logic eo, input logic [3:0] ec,
                          input int hold, input logic rr_early);
      int w;
      res_ready = rr_early;
      for (int i = 0; i < q_op.size(); i++) begin
         send_cmd(q_op[i], q_opd[i], (i == q_op.size() - 1), w);
         if (i > 0) begin
            checks++;
            if (w !== 1) begin
               errors++;
               $display("FAIL %s throughput: waited %0d cycles for cmd_ready, required 1", nm, w);
            end
         end
      end
      tick();
      checks++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL %s latency: res_valid=%b, required 1", nm, res_valid); end
      checks++;
      if (res_data !== ed) begin errors++; $display("FAIL %s res_data: got %h, required %h", nm, res_data, ed); end
      checks++;
      if (res_ovf !== eo) begin errors++; $display("FAIL %s res_ovf: got %b, required %b", nm, res_ovf, eo); end
      checks++;
      if (res_cnt !== ec) begin errors++; $display("FAIL %s res_cnt: got %0d, required %0d", nm, res_cnt, ec); end
      checks++;
      if (acc !== ed) begin errors++; $display("FAIL %s acc: got %h, required %h", nm, acc, ed); end
      if (hold > 0) begin
         res_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== ed || cmd_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s hold: valid=%b data=%h ready=%b, required 1 %h 0",
                        nm, res_valid, res_data, cmd_ready, ed);
            end
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'($urandom);
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== INIT) begin
         errors++;
         $display("FAIL %s handoff: valid=%b ready=%b acc=%h, required 0 1 %h", nm, res_valid, cmd_ready, acc, INIT);
      end
      checks++;
      if (res_data !== 8'h00 || res_ovf !== 1'b0 || res_cnt !== 4'd0) begin
         errors++;
         $display("FAIL %s idle_outputs: data=%h ovf=%b cnt=%0d, required 00 0 0", nm, res_data, res_ovf, res_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_operand = 8'hC3; cmd_last = 1'b1; res_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL reset_handshake: ready=%b valid=%b, required 1 0", cmd_ready, res_valid);
      end
      checks++;
      if (res_data !== 8'h00 || res_ovf !== 1'b0 || res_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_result: data=%h ovf=%b cnt=%0d, required 00 0 0", res_data, res_ovf, res_cnt);
      end
      checks++;
      if (acc !== INIT || alu_a !== INIT || alu_b !== 8'h00 || alu_sel !== 2'd0) begin
         errors++; $display("FAIL reset_alu: acc=%h a=%h b=%h sel=%0d, required %h %h 00 0", acc, alu_a, alu_b, alu_sel, INIT, INIT);
      end
      cmd_valid = 1'b0; res_ready = 1'b0;
   endtask

   task automatic test_directed();
      q_op = '{3'd0, 3'd0}; q_opd = '{8'h53, 8'h94};
      run_seq("add_add", 8'hE7, 1'b0, 4'd2, 0, 1'b1);
      q_op = '{3'd4, 3'd0}; q_opd = '{8'hD5, 8'h78};
`ifdef PALU_SAT_ADD_EN
      run_seq("load_add_ovf", 8'hFF, 1'b1, 4'd2, 0, 1'b0);
`else
      run_seq("load_add_ovf", 8'h4D, 1'b1, 4'd2, 0, 1'b0);
`endif
      q_op = '{3'd4, 3'd1}; q_opd = '{8'h00, 8'hAA};
      run_seq("not", 8'h55, 1'b0, 4'd2, 0, 1'b1);
      q_op = '{3'd4, 3'd2}; q_opd = '{8'hB8, 8'hE7};
      run_seq("and", 8'hA0, 1'b0, 4'd2, 1, 1'b0);
      q_op = '{3'd4, 3'd3}; q_opd = '{8'hB5, 8'hD7};
      run_seq("or", 8'hF7, 1'b0, 4'd2, 0, 1'b0);
      q_op = '{3'd4}; q_opd = '{8'h9E};
      run_seq("single", 8'h9E, 1'b0, 4'd1, 0, 1'b1);
      q_op = '{3'd4, 3'd4, 3'd5}; q_opd = '{8'hFF, 8'h10, 8'h22};
      run_seq("load_no_ovf", 8'h10, 1'b0, 4'd3, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      int w;
      res_ready = 1'b0;
      send_cmd(3'd4, 8'h11, 1'b0, w);
      send_cmd(3'd0, 8'h22, 1'b1, w);
      tick();
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_operand = 8'h3C; cmd_last = 1'b1;
      for (int h = 0; h < 5; h++) begin
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_data !== 8'h33 || res_cnt !== 4'd2 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h cnt=%0d ready=%b, required 1 33 2 0",
                     res_valid, res_data, res_cnt, cmd_ready);
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== INIT) begin
         errors++; $display("FAIL bp_handoff: valid=%b ready=%b acc=%h, required 0 1 %h", res_valid, cmd_ready, acc, INIT);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_next: cmd_ready=%b, required 0", cmd_ready); end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h3C || res_cnt !== 4'd1) begin
         errors++; $display("FAIL bp_held_cmd: valid=%b data=%h cnt=%0d, required 1 3c 1", res_valid, res_data, res_cnt);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_saturation();
      q_op.delete(); q_opd.delete();
      for (int i = 0; i < 18; i++) begin
         q_op.push_back(3'($urandom_range(5, 7)));
         q_opd.push_back(8'($urandom));
      end
      run_seq("nop_sat18", INIT, 1'b0, 4'd15, 0, 1'b0);
      q_op.delete(); q_opd.delete();
      for (int i = 0; i < 15; i++) begin
         q_op.push_back(3'd5 + 3'(i % 3));
         q_opd.push_back(8'($urandom));
      end
      run_seq("nop_15", INIT, 1'b0, 4'd15, 0, 1'b1);
   endtask

   task automatic test_mid_reset();
      int w;
      res_ready = 1'b0;
      send_cmd(3'd4, 8'h80, 1'b0, w);
      send_cmd(3'd0, 8'hFF, 1'b0, w);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || acc !== INIT || res_ovf !== 1'b0 || alu_b !== 8'h00) begin
         errors++; $display("FAIL rst_exec: ready=%b valid=%b acc=%h ovf=%b b=%h, required 1 0 %h 0 00",
                            cmd_ready, res_valid, acc, res_ovf, alu_b, INIT);
      end
      send_cmd(3'd4, 8'h77, 1'b1, w);
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h77 || res_cnt !== 4'd1) begin
         errors++; $display("FAIL rst_prehold: valid=%b data=%h cnt=%0d, required 1 77 1", res_valid, res_data, res_cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      res_ready = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || acc !== INIT || res_data !== 8'h00) begin
         errors++; $display("FAIL rst_hold: ready=%b valid=%b acc=%h data=%h, required 1 0 %h 00",
                            cmd_ready, res_valid, acc, res_data, INIT);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_dropped: res_valid=%b, required 0", res_valid); end
      end
      q_op = '{3'd4, 3'd5}; q_opd = '{8'h01, 8'h00};
      run_seq("after_rst", 8'h01, 1'b0, 4'd2, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] ed;
      logic       eo;
      logic [3:0] ec;
      q_op = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2}; q_opd = '{8'hF0, 8'h20, 8'h05, 8'h01, 8'h0F};
      ref_model(ed, eo, ec);
      run_seq("b2b", ed, eo, ec, 0, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] ed;
      logic       eo;
      logic [3:0] ec;
      int         n;
      for (int s = 0; s < 30; s++) begin
         q_op.delete(); q_opd.delete();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            q_op.push_back(3'($urandom_range(0, 7)));
            q_opd.push_back(8'($urandom));
         end
         ref_model(ed, eo, ec);
         run_seq($sformatf("rand%0d", s), ed, eo, ec, $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h00; cmd_last = 1'b0; res_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_saturation();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
